// File: rtl/turn_signal_pkg.sv
// Shared types and helpers for the turn_signal_seq tail-light sequencer.
package turn_signal_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEQ_L   = 3'd1,
    SEQ_R   = 3'd2,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4
  } state_t;

  localparam int unsigned MAX_LIGHTS = 16;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Low k bits set, limited to the first 'lights' lamps.
  function automatic logic [MAX_LIGHTS-1:0] thermometer(input int unsigned k,
                                                        input int unsigned lights);
    logic [MAX_LIGHTS-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < MAX_LIGHTS; i++) begin
      t[i] = (i < k) && (i < lights);
    end
    return t;
  endfunction

endpackage

// File: rtl/turn_signal_prescaler.sv
// Step prescaler: one tick every TICK_DIV cycles, restartable, optionally
// parked at the terminal count so an idle sequencer reacts on the next edge.
module turn_signal_prescaler
  import turn_signal_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic sat,
  output logic tick
);

  localparam int unsigned CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] P_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p <= P_LAST;
    end else if (clr) begin
      r_p <= '0;
    end else if (r_p == P_LAST) begin
      r_p <= sat ? P_LAST : '0;
    end else begin
      r_p <= r_p + CW'(1);
    end
  end

  assign tick = (r_p == P_LAST);

endmodule

// File: rtl/turn_signal_seq.sv
// Left/right thermometer-sweep tail-light sequencer with hazard flashing.
// Optional completed-sweep counter output enabled by defining TURNSIG_CNT_EN.
module turn_signal_seq
  import turn_signal_pkg::*;
#(
  parameter int unsigned LIGHTS   = 3,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              left,
  input  logic              right,
  input  logic              hazard,
  output logic [LIGHTS-1:0] lightsL,
  output logic [LIGHTS-1:0] lightsR,
  output logic              busy
`ifdef TURNSIG_CNT_EN
  ,
  output logic [15:0]       sweep_cnt
`endif
);

  localparam int unsigned KW = cnt_width(LIGHTS + 1);
  localparam logic [KW-1:0] K_LAST = KW'(LIGHTS);

  state_t            r_state, w_state_nx;
  logic [KW-1:0]     r_k, w_k_nx;
  logic              w_tick;
  logic              w_clr;
  logic              w_sat;
  logic              w_haz_req;
  logic [LIGHTS-1:0] w_therm;

  // Both turn stalks together are treated as a hazard request.
  assign w_haz_req = hazard | (left & right);
  assign w_therm   = LIGHTS'(thermometer(32'(r_k), LIGHTS));
  assign w_clr     = (w_state_nx != r_state);
  assign w_sat     = (r_state == IDLE);

  turn_signal_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .sat   (w_sat),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    lightsL    = '0;
    lightsR    = '0;
    busy       = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          if (w_haz_req) begin
            w_state_nx = HAZ_ON;
          end else if (left) begin
            w_state_nx = SEQ_L;
            w_k_nx     = KW'(1);
          end else if (right) begin
            w_state_nx = SEQ_R;
            w_k_nx     = KW'(1);
          end
        end
      end
      SEQ_L, SEQ_R: begin
        if (r_state == SEQ_L) lightsL = w_therm;
        else                  lightsR = w_therm;
        if (hazard) begin
          w_state_nx = HAZ_ON;
        end else if (w_tick) begin
          if (r_k == K_LAST) begin
            w_state_nx = IDLE;
            w_k_nx     = '0;
          end else begin
            w_k_nx = r_k + KW'(1);
          end
        end
      end
      HAZ_ON: begin
        lightsL = '1;
        lightsR = '1;
        if (w_tick) w_state_nx = HAZ_OFF;
      end
      HAZ_OFF: begin
        if (w_tick) w_state_nx = w_haz_req ? HAZ_ON : IDLE;
      end
      default: begin
        w_state_nx = IDLE;
        w_k_nx     = '0;
      end
    endcase
  end

`ifdef TURNSIG_CNT_EN
  logic        w_sweep_done;
  logic [15:0] r_sweep_cnt;

  // A final-step tick with hazard present is an abort, not a completion.
  assign w_sweep_done = ((r_state == SEQ_L) || (r_state == SEQ_R)) && !hazard &&
                        w_tick && (r_k == K_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sweep_cnt <= '0;
    end else if (w_sweep_done && (r_sweep_cnt != 16'hFFFF)) begin
      r_sweep_cnt <= r_sweep_cnt + 16'd1;
    end
  end

  assign sweep_cnt = r_sweep_cnt;
`endif

endmodule

// File: tb/tb_turn_signal_seq.sv
// Directed bench for turn_signal_seq across four LIGHTS/TICK_DIV configurations.
module tb_turn_signal_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_d;
  logic left_a, right_a, haz_a;
  logic left_b, right_b, haz_b;
  logic left_c, right_c, haz_c;
  logic left_d, right_d, haz_d;
  logic [2:0] l_a, r_a, l_c, r_c, l_d, r_d;
  logic [3:0] l_b, r_b;
  logic busy_a, busy_b, busy_c, busy_d;
`ifdef TURNSIG_CNT_EN
  logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [2:0] sweep3 [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
  logic       busy3  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] tbl_b  [6] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h0, 4'h1};
  logic [2:0] tbl_c  [8] = '{3'h7, 3'h7, 3'h0, 3'h0, 3'h7, 3'h7, 3'h0, 3'h0};

  turn_signal_seq #(.LIGHTS(3), .TICK_DIV(1)) u_a (
    .clk(clk), .reset(rst), .left(left_a), .right(right_a), .hazard(haz_a),
    .lightsL(l_a), .lightsR(r_a), .busy(busy_a)
`ifdef TURNSIG_CNT_EN
    , .sweep_cnt(cnt_a)
`endif
  );

  turn_signal_seq #(.LIGHTS(4), .TICK_DIV(4)) u_b (
    .clk(clk), .reset(rst), .left(left_b), .right(right_b), .hazard(haz_b),
    .lightsL(l_b), .lightsR(r_b), .busy(busy_b)
`ifdef TURNSIG_CNT_EN
    , .sweep_cnt(cnt_b)
`endif
  );

  turn_signal_seq #(.LIGHTS(3), .TICK_DIV(2)) u_c (
    .clk(clk), .reset(rst), .left(left_c), .right(right_c), .hazard(haz_c),
    .lightsL(l_c), .lightsR(r_c), .busy(busy_c)
`ifdef TURNSIG_CNT_EN
    , .sweep_cnt(cnt_c)
`endif
  );

  turn_signal_seq #(.LIGHTS(3), .TICK_DIV(3)) u_d (
    .clk(clk), .reset(rst_d), .left(left_d), .right(right_d), .hazard(haz_d),
    .lightsL(l_d), .lightsR(r_d), .busy(busy_d)
`ifdef TURNSIG_CNT_EN
    , .sweep_cnt(cnt_d)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_a(input string tag);
    left_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      left_a = 1'b0;
      check({tag, "_L"}, 32'(l_a), 32'(sweep3[i]));
      check({tag, "_R"}, 32'(r_a), 32'd0);
      check({tag, "_busy"}, 32'(busy_a), 32'(busy3[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rst_d = 1'b1;
    {left_a, right_a, haz_a, left_b, right_b, haz_b} = '0;
    {left_c, right_c, haz_c, left_d, right_d, haz_d} = '0;
    cyc();
    cyc();
    check("rst_a", 32'({l_a, r_a, busy_a}), 32'd0);
    check("rst_b", 32'({l_b, r_b, busy_b}), 32'd0);
    check("rst_c", 32'({l_c, r_c, busy_c}), 32'd0);
    check("rst_d", 32'({l_d, r_d, busy_d}), 32'd0);
`ifdef TURNSIG_CNT_EN
    check("rst_cnt", 32'(cnt_a), 32'd0);
`endif
    rst = 1'b0; rst_d = 1'b0;

    // single left pulse, immediate acceptance after reset
    sweep_a("A1");
`ifdef TURNSIG_CNT_EN
    check("cnt_1", 32'(cnt_a), 32'd1);
`endif

    // right held: 4-cycle steps, one 4-cycle off step, then repeat
    right_b = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      check("B_R", 32'(r_b), 32'(tbl_b[i/4]));
      check("B_L", 32'(l_b), 32'd0);
    end
    right_b = 1'b0;
    repeat (16) cyc();
    check("B_end", 32'({r_b, busy_b}), 32'd0);

    // left+right together flash both banks
    left_c = 1'b1; right_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("C_L", 32'(l_c), 32'(tbl_c[i]));
      check("C_R", 32'(r_c), 32'(tbl_c[i]));
      check("C_busy", 32'(busy_c), 32'd1);
    end
    left_c = 1'b0; right_c = 1'b0;
    cyc();
    check("C_end", 32'({l_c, r_c, busy_c}), 32'd0);
    // hazard beats left; must still wait out the minimum off step
    haz_c = 1'b1; left_c = 1'b1;
    cyc();
    check("C_offmin", 32'({l_c, busy_c}), 32'd0);
    cyc();
    check("C_hprioL", 32'(l_c), 32'h7);
    check("C_hprioR", 32'(r_c), 32'h7);
    haz_c = 1'b0; left_c = 1'b0;
    repeat (8) cyc();
    check("C_drain", 32'({l_c, r_c, busy_c}), 32'd0);

    // hazard aborts a left sweep at 011
    left_a = 1'b1;
    cyc();
    left_a = 1'b0;
    check("D_k1", 32'(l_a), 32'h1);
    cyc();
    check("D_k2", 32'(l_a), 32'h3);
    haz_a = 1'b1;
    cyc();
    check("D_onL", 32'(l_a), 32'h7);
    check("D_onR", 32'(r_a), 32'h7);
    haz_a = 1'b0;
    cyc();
    check("D_off", 32'({l_a, r_a}), 32'd0);
    check("D_offbusy", 32'(busy_a), 32'd1);
    cyc();
    check("D_idle", 32'({l_a, r_a, busy_a}), 32'd0);

    sweep_a("A2");
    sweep_a("A3");
`ifdef TURNSIG_CNT_EN
    check("cnt_3", 32'(cnt_a), 32'd3);
`endif

    // reset mid-sweep at 011 with TICK_DIV=3
    left_d = 1'b1;
    cyc();
    left_d = 1'b0;
    check("E_k1a", 32'(l_d), 32'h1);
    cyc();
    check("E_k1b", 32'(l_d), 32'h1);
    cyc();
    check("E_k1c", 32'(l_d), 32'h1);
    cyc();
    check("E_k2", 32'(l_d), 32'h3);
    rst_d = 1'b1;
    cyc();
    check("E_rst", 32'({l_d, r_d, busy_d}), 32'd0);
    rst_d = 1'b0; left_d = 1'b1;
    cyc();
    left_d = 1'b0;
    check("E_restart", 32'(l_d), 32'h1);
    check("E_busy", 32'(busy_d), 32'd1);
    check("E_R", 32'(r_d), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
